timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Sequencer for the DMG timer (TIMA/TMA/TAC at FF05–FF07).
- Takes the free-running divider taps from the clock/reset block and selects one per TAC. Detects the counting edge and increments TIMA.
- Runs the overflow → delay → reload-from-TMA sequence and raises the timer interrupt request.
- Arbitrates CPU register writes against in-flight increment and reload events.

Parameters:
- RELOAD_DELAY, 1, machine cycles TIMA holds 8'h00 after overflow before the TMA reload; legal values 0..3.
- TAC_PAD, 5'b11111, value returned on d_out[7:3] for TAC reads.

Ports:
- boga1mhz  input  1  machine-cycle clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ff04_ff07  input  1  address decode hit for FF04–FF07.
- tovy_na0  input  1  inverted A0, as supplied by the address decoder.
- tola_na1  input  1  inverted A1, as supplied by the address decoder.
- cpu_wr  input  1  CPU write strobe, one cycle per access.
- cpu_rd  input  1  CPU read strobe.
- d_in  input  8  write data.
- d_out  output  8  read data.
- d_oe  output  1  drive enable for d_out; high only for reads of FF05–FF07.
- _262144hz  input  1  divider tap.
- _65536hz  input  1  divider tap.
- _16384hz  input  1  divider tap.
- _4096hz  input  1  divider tap.
- int_timer  output  1  one-cycle interrupt request pulse.
- tima_q  output  8  current TIMA value, for debug/observation.

Behaviour:
- Address: a = {!tola_na1, !tovy_na0}. a=0 (DIV) is never driven by this block. a=1 TIMA, a=2 TMA, a=3 TAC.
- Reset: TIMA, TMA, TAC[2:0] = 0; state IDLE; edge register = 0; int_timer = 0; d_oe = 0; d_out = 8'h00.
- Reads are combinational:
  - d_oe = ff04_ff07 & cpu_rd & (a != 0).
  - d_out = TIMA, TMA, or {TAC_PAD, TAC}; 8'h00 when d_oe is low.
- Tap select: TAC[1:0] 00→_4096hz, 01→_262144hz, 10→_65536hz, 11→_16384hz. tsig = selected tap & TAC[2].
- Edge detect: tsig_q registered every cycle. tick = tsig_q & !tsig (falling edge).
- States: IDLE, OVF, RELOAD.
- IDLE:
  - Tick with TIMA != FF: TIMA += 1.
  - Tick with TIMA == FF: TIMA = 00. If RELOAD_DELAY = 0, go straight to the RELOAD action in the same cycle; otherwise go to OVF with dcnt = RELOAD_DELAY − 1.
- OVF:
  - dcnt decrements each cycle; go to RELOAD when dcnt = 0.
  - A tick in OVF increments TIMA (00 → 01); the reload still follows.
- RELOAD (one cycle): TIMA ← TMA, int_timer = 1, then return to IDLE.
- Write priority:
  - TIMA write in IDLE: the write wins over a same-cycle tick. No increment and no overflow occur.
  - TIMA write in OVF: the write wins, the reload is cancelled, no int_timer, return to IDLE.
  - TIMA write in RELOAD: ignored; the TMA value is loaded.
  - TMA write in RELOAD: TMA ← d_in and TIMA ← d_in (write data forwarded).
  - TAC write: new TAC takes effect next cycle. A resulting falling edge of tsig produces a tick, including disable while the tap is high (DMG glitch).
- A DIV reset drops all taps. A tap that was high therefore produces a tick; this is required.
- Reset asserted mid-sequence: abort OVF/RELOAD, no int_timer pulse.
- tima_q mirrors TIMA at all times.

Optional Feature:
- Macro: TIMER_GLITCH_EN.
- Defined: edge detection on the muxed, enable-gated tsig exactly as specified in Behaviour; TAC writes and DIV resets can generate spurious ticks.
- Undefined: in any cycle with a TAC write, tsig_q is loaded with the new tsig value and tick is suppressed, so only genuine falling edges of the selected tap (while enabled) count. All other behaviour is identical.

Test Plan:
- Count at 4096: TAC=3'b100, TIMA=8'hFD. Toggle _4096hz 3 periods → TIMA FE, FF, 00. int_timer pulses exactly once, RELOAD_DELAY+1 cycles after the 00 edge; TIMA = TMA (8'h42).
- Write cancels reload: TIMA overflows, then TIMA write 8'h10 during OVF → TIMA = 8'h10, no int_timer, state IDLE.
- Forwarding in RELOAD: TMA = 8'h42; TMA write 8'h99 in the RELOAD cycle → TIMA = 8'h99, TMA = 8'h99, int_timer = 1.
- Glitch tick (macro defined): TAC = 3'b101 with _262144hz high; write TAC = 3'b001 → TIMA increments by 1. Same stimulus with the macro undefined → no increment.
- Same-cycle write vs tick: TIMA = 8'hFF, tick and TIMA write 8'h05 in the same cycle → TIMA = 8'h05, no overflow, no int_timer.
- Readback and reset: TAC = 3'b110 reads 8'hFE; a=0 read → d_oe = 0. Reset asserted during OVF → all registers 0, no int_timer.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// CPU-side register bus for the timer block (FF04-FF07 window).
interface timer_ctrl_if;
  logic       ff04_ff07;
  logic       tovy_na0;
  logic       tola_na1;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output ff04_ff07, tovy_na0, tola_na1, cpu_wr, cpu_rd, d_in,
    input  d_out, d_oe
  );

  modport slave (
    input  ff04_ff07, tovy_na0, tola_na1, cpu_wr, cpu_rd, d_in,
    output d_out, d_oe
  );
endinterface

// File: rtl/timer_ctrl.sv
// DMG timer sequencer: TIMA/TMA/TAC, tap select, edge detect, overflow/reload.
// Optional macro TIMER_GLITCH_EN: when defined, TAC writes and DIV resets may
// produce spurious ticks (raw falling edge of the gated tap). When undefined,
// a TAC write re-seeds the edge register and suppresses that cycle's tick.
module timer_ctrl #(
  parameter int unsigned RELOAD_DELAY = 1,
  parameter logic [4:0]  TAC_PAD      = 5'b11111
) (
  input  logic             boga1mhz,
  input  logic             reset,
  timer_ctrl_if.slave      bus,
  input  logic             _262144hz,
  input  logic             _65536hz,
  input  logic             _16384hz,
  input  logic             _4096hz,
  output logic             int_timer,
  output logic [7:0]       tima_q
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] DCNT_INIT =
    (RELOAD_DELAY == 0) ? CW'(0) : CW'(RELOAD_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] dcnt, dcnt_d;
  logic [DW-1:0] tima, tima_d;
  logic [DW-1:0] tma, tma_d;
  logic [2:0]    tac, tac_d;
  logic          tsig_q, tsig_d;
  logic          int_d;

  logic [1:0]    addr;
  logic          wr_tima, wr_tma, wr_tac;
  logic [3:0]    taps;
  logic          tsig, tick;

  // Gated tap for a given TAC value; index order matches TAC[1:0] encoding.
  function automatic logic tap_sel(input logic [2:0] t, input logic [3:0] tp);
    return t[2] & tp[t[1:0]];
  endfunction

  assign addr    = {~bus.tola_na1, ~bus.tovy_na0};
  assign wr_tima = bus.ff04_ff07 & bus.cpu_wr & (addr == 2'd1);
  assign wr_tma  = bus.ff04_ff07 & bus.cpu_wr & (addr == 2'd2);
  assign wr_tac  = bus.ff04_ff07 & bus.cpu_wr & (addr == 2'd3);
  assign taps    = {_16384hz, _65536hz, _262144hz, _4096hz};
  assign tsig    = tap_sel(tac, taps);
  assign tima_q  = tima;

  // Falling-edge tick and next edge-register value.
  always_comb begin
`ifdef TIMER_GLITCH_EN
    tick   = tsig_q & ~tsig;
    tsig_d = tsig;
`else
    tick   = tsig_q & ~tsig & ~wr_tac;
    tsig_d = wr_tac ? tap_sel(bus.d_in[2:0], taps) : tsig;
`endif
  end

  // Combinational register readback; DIV (a=0) belongs to another block.
  always_comb begin
    bus.d_oe  = bus.ff04_ff07 & bus.cpu_rd & (addr != 2'd0);
    bus.d_out = 8'h00;
    if (bus.d_oe) begin
      case (addr)
        2'd1:    bus.d_out = tima;
        2'd2:    bus.d_out = tma;
        2'd3:    bus.d_out = {TAC_PAD, tac};
        default: bus.d_out = 8'h00;
      endcase
    end
  end

  // Next-state: count, overflow delay, reload, and CPU write arbitration.
  always_comb begin
    state_d = state;
    dcnt_d  = dcnt;
    tima_d  = tima;
    tma_d   = tma;
    tac_d   = tac;
    int_d   = 1'b0;

    if (wr_tma) tma_d = bus.d_in;
    if (wr_tac) tac_d = bus.d_in[2:0];

    case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_d = bus.d_in;
        end else if (tick) begin
          if (tima == 8'hFF) begin
            tima_d = 8'h00;
            if (RELOAD_DELAY == 0) begin
              state_d = RELOAD;
              int_d   = 1'b1;
            end else begin
              state_d = OVF;
              dcnt_d  = DCNT_INIT;
            end
          end else begin
            tima_d = DW'(tima + 8'd1);
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_d  = bus.d_in;
          state_d = IDLE;
        end else begin
          if (tick) tima_d = DW'(tima + 8'd1);
          if (dcnt == '0) begin
            state_d = RELOAD;
            int_d   = 1'b1;
          end else begin
            dcnt_d = CW'(dcnt - 2'd1);
          end
        end
      end
      RELOAD: begin
        tima_d  = wr_tma ? bus.d_in : tma;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge boga1mhz) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= '0;
      tima      <= '0;
      tma       <= '0;
      tac       <= '0;
      tsig_q    <= 1'b0;
      int_timer <= 1'b0;
    end else begin
      state     <= state_d;
      dcnt      <= dcnt_d;
      tima      <= tima_d;
      tma       <= tma_d;
      tac       <= tac_d;
      tsig_q    <= tsig_d;
      int_timer <= int_d;
    end
  end

endmodule
